// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM encoding, funct3 codes and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;
  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: single-port external memory bus, arbiter is master and memory is slave
interface mem_bus_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable/write-lane generation, load lane extraction/extension and misalign detect
module mem_lane_align
  import mem_bus_arbiter_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ld_data,
  output logic        misalign
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v     = rdata[{addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    misalign   = (funct[1:0] == 2'b01 && addr_lo[0]) || (funct == F_LW && addr_lo != 2'b00);
    be         = !we ? 4'hf :
                 funct == F_SB ? 4'b0001 << addr_lo :
                 funct == F_SH ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'hf;
    lane_wdata = funct == F_SB ? {4{wdata[7:0]}} :
                 funct == F_SH ? {2{wdata[15:0]}} : wdata;
    ld_data    = funct == F_LB  ? {{24{byte_v[7]}}, byte_v} :
                 funct == F_LH  ? {{16{half_v[15]}}, half_v} :
                 funct == F_LBU ? {24'b0, byte_v} :
                 funct == F_LHU ? {16'b0, half_v} : rdata;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data ports, data-first with anti-starvation and timeout
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  mem_bus_arbiter_if.master bus
);
  localparam int SK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SK_W-1:0] SK_MAX = SK_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);
  state_t state, state_nx;
  logic own_d, we_q, err_q;
  logic [2:0] funct_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0] be_q;
  logic [CNT_W-1:0] cnt;
  logic [SK_W-1:0] streak;
  logic d_req, in_bus, fetch_win, grant_d, grant_f, timed_out;
  logic a_we, misalign;
  logic [2:0] a_funct;
  logic [1:0] a_lo;
  logic [3:0] be;
  logic [31:0] lane_wdata, ld_data;
  always_comb begin
    d_req     = d_rd | d_wr;
    in_bus    = state == FETCH || state == DATA;
    fetch_win = if_req && (!d_req || streak == SK_MAX);
    grant_d   = state == IDLE && d_req && !fetch_win;
    grant_f   = state == IDLE && fetch_win;
    timed_out = in_bus && !bus.mem_ack && cnt == CNT_END;
    a_we      = state == IDLE ? d_wr : we_q;
    a_funct   = state == IDLE ? d_funct : funct_q;
    a_lo      = state == IDLE ? d_addr[1:0] : addr_q[1:0];
  end
  // Store lanes/misalign come from live inputs in IDLE, load extension from the registered request
  mem_lane_align u_align (
    .we        (a_we),
    .funct     (a_funct),
    .addr_lo   (a_lo),
    .wdata     (d_wdata),
    .rdata     (bus.mem_rdata),
    .be        (be),
    .lane_wdata(lane_wdata),
    .ld_data   (ld_data),
    .misalign  (misalign)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:        state_nx = grant_d ? (misalign ? RESP : DATA) : grant_f ? FETCH : IDLE;
      FETCH, DATA: state_nx = (bus.mem_ack || timed_out) ? RESP : state;
      RESP:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      own_d   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      funct_q <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      be_q    <= 4'b0;
      cnt     <= '0;
      streak  <= '0;
    end else begin
      if (grant_d || grant_f) begin
        own_d   <= grant_d;
        we_q    <= grant_d && d_wr;
        err_q   <= grant_d && misalign;
        funct_q <= d_funct;
        addr_q  <= grant_d ? d_addr : if_addr;
        wdata_q <= grant_d ? lane_wdata : 32'b0;
        be_q    <= grant_d ? be : 4'hf;
        rdata_q <= 32'b0;
        cnt     <= '0;
      end else if (in_bus) begin
        if (bus.mem_ack) rdata_q <= own_d ? ld_data : bus.mem_rdata;
        else if (timed_out) begin
          rdata_q <= own_d ? 32'b0 : NOP;
          err_q   <= own_d;
        end else cnt <= cnt + 1'b1;
      end
      if (state == IDLE)
        streak <= (!if_req || grant_f) ? '0 : (grant_d && streak != SK_MAX) ? streak + 1'b1 : streak;
    end
  always_comb begin
    bus.mem_req   = in_bus;
    bus.mem_we    = in_bus && we_q;
    bus.mem_addr  = {addr_q[31:2], 2'b00};
    bus.mem_wdata = wdata_q;
    bus.mem_be    = be_q;
    if_ready      = state == RESP && !own_d;
    d_ready       = state == RESP && own_d;
    d_err         = state == RESP && own_d && err_q;
    if_rdata      = rdata_q;
    d_rdata       = rdata_q;
  end
endmodule
